// File: rtl/seq_detect_param.sv
// Serial pattern detector with runtime-configurable pattern, length and overlap
// mode, plus a saturating match counter with a sticky saturation flag.
module seq_detect_param #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   pat_len,
  input  logic               overlap,
  input  logic               inp_valid,
  input  logic               inp_bit,
  input  logic               clear,
  output logic               seq_seen,
  output logic [CNT_W-1:0]   match_count,
  output logic               count_sat
);

  // Input handshake: inp_bit is consumed on every rising edge where inp_valid=1
  // and cfg_load=0; there is no backpressure, so the block is always ready.

  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic               ovl_q;
  logic               seen_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sat_q, sat_d;

  logic [LEN_W-1:0]   eff_len;
  logic [MAX_LEN-1:0] mask;
  logic [MAX_LEN-1:0] hist_shift;
  logic [LEN_W-1:0]   fill_inc;
  logic               match;

  assign eff_len    = (len_q > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len_q;
  assign hist_shift = {hist_q[MAX_LEN-2:0], inp_bit};
  assign fill_inc   = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);

  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LEN_W'(i) < eff_len);
    end
  end

  // Match is judged on the values the shift would produce this edge.
  assign match = inp_valid && !cfg_load && (eff_len != '0) && (fill_inc >= eff_len)
                 && (((hist_shift ^ pat_q) & mask) == '0);

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (cfg_load) begin
      fill_d = '0;
    end else if (inp_valid) begin
      hist_d = hist_shift;
      fill_d = (match && !ovl_q) ? '0 : fill_inc;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (clear) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (match) begin
      if (cnt_q == '1) sat_d = 1'b1;
      else             cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= '0;
      len_q  <= '0;
      ovl_q  <= 1'b1;
      seen_q <= 1'b0;
      cnt_q  <= '0;
      sat_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      seen_q <= match;
      cnt_q  <= cnt_d;
      sat_q  <= sat_d;
      if (cfg_load) begin
        pat_q <= pattern;
        len_q <= pat_len;
        ovl_q <= overlap;
      end
    end
  end

  assign seq_seen    = seen_q;
  assign match_count = cnt_q;
  assign count_sat   = sat_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: a bit-queue reference model scored every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_seq_detect_param;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int W       = 13;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               cfg_load = 1'b0;
  logic [MAX_LEN-1:0] pattern = '0;
  logic [LEN_W-1:0]   pat_len = '0;
  logic               overlap = 1'b0;
  logic               inp_valid = 1'b0;
  logic               inp_bit = 1'b0;
  logic               clear = 1'b0;

  logic       seq_seen, count_sat, seq_seen2, count_sat2;
  logic [7:0] match_count;
  logic [1:0] match_count2;

  int tests_run = 0;
  int tests_failed = 0;
  int pulse_cnt = 0;

  seq_detect_param #(.MAX_LEN(MAX_LEN), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .pattern(pattern),
    .pat_len(pat_len), .overlap(overlap), .inp_valid(inp_valid),
    .inp_bit(inp_bit), .clear(clear), .seq_seen(seq_seen),
    .match_count(match_count), .count_sat(count_sat)
  );

  seq_detect_param #(.MAX_LEN(MAX_LEN), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .pattern(pattern),
    .pat_len(pat_len), .overlap(overlap), .inp_valid(inp_valid),
    .inp_bit(inp_bit), .clear(clear), .seq_seen(seq_seen2),
    .match_count(match_count2), .count_sat(count_sat2)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model: bits accepted since the last fill reset, newest at the back
  bit         m_bits[$];
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ovl;
  bit         m_seen;
  int         m_cnt, m_cnt2;
  bit         m_sat, m_sat2;
  logic [W-1:0] exp_q[$];

  task automatic model_reset();
    m_bits.delete();
    m_pat = '0; m_len = 0; m_ovl = 1'b1; m_seen = 1'b0;
    m_cnt = 0; m_cnt2 = 0; m_sat = 1'b0; m_sat2 = 1'b0;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model_reset();
      if (clk) exp_q.push_back('0);
    end else begin
      int l;
      bit hit;
      m_seen = 1'b0;
      if (cfg_load) begin
        m_pat = pattern; m_len = int'(pat_len); m_ovl = overlap;
        m_bits.delete();
      end else if (inp_valid) begin
        m_bits.push_back(inp_bit);
        if (m_bits.size() > MAX_LEN) void'(m_bits.pop_front());
        l = (m_len > MAX_LEN) ? MAX_LEN : m_len;
        if (l > 0 && m_bits.size() >= l) begin
          hit = 1'b1;
          for (int k = 0; k < l; k++)
            if (m_bits[m_bits.size() - l + k] != m_pat[l - 1 - k]) hit = 1'b0;
          if (hit) begin
            m_seen = 1'b1;
            if (!m_ovl) m_bits.delete();
          end
        end
      end
      if (clear) begin
        m_cnt = 0; m_sat = 1'b0; m_cnt2 = 0; m_sat2 = 1'b0;
      end else if (m_seen) begin
        if (m_cnt == 255) m_sat = 1'b1; else m_cnt++;
        if (m_cnt2 == 3) m_sat2 = 1'b1; else m_cnt2++;
      end
      exp_q.push_back({m_seen, 8'(m_cnt), m_sat, 2'(m_cnt2), m_sat2});
    end
  end

  // scoreboard: one comparison per clock against the model
  always @(negedge clk) begin
    logic [W-1:0] act, exp_v;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act = {seq_seen, match_count, count_sat, match_count2, count_sat2};
      tests_run++;
      if (act !== exp_v) begin
        tests_failed++;
        $display("FAIL model_cmp t=%0t got seen=%b cnt=%0d sat=%b cnt2=%0d sat2=%b want seen=%b cnt=%0d sat=%b cnt2=%0d sat2=%b",
                 $time, act[12], act[11:4], act[3], act[2:1], act[0],
                 exp_v[12], exp_v[11:4], exp_v[3], exp_v[2:1], exp_v[0]);
      end
      if (seq_seen) pulse_cnt++;
    end
  end

  // driver tasks: each drives one cycle starting just after a falling edge
  task automatic cyc(input bit v, input bit b, input bit ld, input bit clr);
    inp_valid = v; inp_bit = b; cfg_load = ld; clear = clr;
    @(negedge clk); #1;
    inp_valid = 1'b0; cfg_load = 1'b0; clear = 1'b0;
  endtask

  task automatic feed(input bit b);
    cyc(1'b1, b, 1'b0, 1'b0);
  endtask

  task automatic load_cfg(input logic [7:0] p, input int l, input bit o);
    pattern = p; pat_len = LEN_W'(l); overlap = o;
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic do_clear();
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    pulse_cnt = 0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic check(input string name, input int act, input int exp_v);
    tests_run++;
    if (act != exp_v) begin
      tests_failed++;
      $display("FAIL %s got %0d want %0d", name, act, exp_v);
    end
  endtask

  initial begin
    logic [3:0] s7;
    @(negedge clk); #1;
    reset = 1'b1;
    @(negedge clk); #1;
    check("reset_cnt", int'(match_count), 0);
    check("reset_seen", int'(seq_seen), 0);
    @(negedge clk); #1;
    reset = 1'b0;
    @(negedge clk); #1;

    // overlapping detection of 1011 in 1011011
    do_clear();
    load_cfg(8'b0000_1011, 4, 1'b1);
    feed(1); feed(0); feed(1); feed(1);
    check("ovl_pulse_bit4", int'(seq_seen), 1);
    feed(0); feed(1); feed(1);
    check("ovl_pulse_bit7", int'(seq_seen), 1);
    cyc(0, 0, 0, 0);
    check("ovl_count", int'(match_count), 2);
    check("ovl_pulses", pulse_cnt, 2);

    // non-overlapping on the same stream
    do_clear();
    load_cfg(8'b0000_1011, 4, 1'b0);
    feed(1); feed(0); feed(1); feed(1); feed(0); feed(1); feed(1);
    cyc(0, 0, 0, 0);
    check("novl_count", int'(match_count), 1);
    check("novl_pulses", pulse_cnt, 1);

    // zero length disables detection
    do_clear();
    load_cfg(8'h00, 0, 1'b1);
    for (int i = 0; i < 12; i++) feed(1'($urandom_range(0, 1)));
    check("len0_count", int'(match_count), 0);
    check("len0_pulses", pulse_cnt, 0);

    // saturation on the 2-bit counter instance
    do_clear();
    load_cfg(8'h01, 1, 1'b1);
    feed(1); feed(1); feed(1);
    check("sat_cnt3", int'(match_count2), 3);
    check("sat_flag_pre", int'(count_sat2), 0);
    feed(1);
    check("sat_flag_4th", int'(count_sat2), 1);
    feed(1);
    check("sat_cnt_hold", int'(match_count2), 3);
    do_clear();
    check("sat_clear_cnt", int'(match_count2), 0);
    check("sat_clear_flag", int'(count_sat2), 0);

    // clear coinciding with a match: pulse stays, counter cleared
    cyc(1, 1, 0, 1);
    check("clr_match_seen", int'(seq_seen), 1);
    check("clr_match_cnt", int'(match_count), 0);

    // reset mid-sequence discards history
    do_clear();
    load_cfg(8'b0000_1011, 4, 1'b1);
    feed(1); feed(0); feed(1);
    pulse_reset();
    check("rst_mid_cnt", int'(match_count), 0);
    load_cfg(8'b0000_1011, 4, 1'b1);
    pulse_cnt = 0;
    feed(1);
    check("rst_no_pulse", int'(seq_seen), 0);
    feed(0); feed(1); feed(1);
    check("rst_reload_pulse", int'(seq_seen), 1);

    // valid gaps, then cfg_load on the final-bit edge
    do_clear();
    load_cfg(8'b0000_1011, 4, 1'b1);
    feed(1); cyc(0, 0, 0, 0); feed(0); cyc(0, 1, 0, 0); feed(1); feed(1);
    check("gap_pulse", int'(seq_seen), 1);
    cyc(0, 0, 0, 0);
    check("gap_pulses", pulse_cnt, 1);
    feed(1); feed(0); feed(1);
    cyc(1, 1, 1, 0);
    check("ld_final_no_pulse", int'(seq_seen), 0);
    check("ld_final_cnt", int'(match_count), 1);

    // randomized traffic scored by the model
    for (int n = 0; n < 4000; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        pattern = 8'($urandom);
        pat_len = ($urandom_range(0, 9) == 0) ? LEN_W'($urandom_range(0, 15))
                                               : LEN_W'($urandom_range(1, 4));
        overlap = 1'($urandom_range(0, 1));
        cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
      end else if (r < 4) begin
        pulse_reset();
      end else begin
        s7 = 4'($urandom_range(0, 15));
        pattern = 8'($urandom);
        cyc(s7 != 0 && s7 < 12, 1'($urandom_range(0, 1)), 1'b0, $urandom_range(0, 49) == 0);
      end
    end
    cyc(0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
